// File: rtl/task_7_pkg.sv
// rtl/task_7_pkg.sv - shared types and sizing helpers for the task 7 output stage
package task_7_pkg;

    typedef enum logic [1:0] {
        s_IDLE,
        s_COLLECT,
        s_SEND,
        s_DONE
    } task_output_enum;

    localparam int NUM_WORDS_DEFAULT = 243;

    function automatic int depth_for(input int num_words);
        return 2 ** $clog2(num_words);
    endfunction

endpackage

// File: rtl/task_7_out_buf.sv
// rtl/task_7_out_buf.sv - single-clock frame buffer with fall-through read
module task_7_out_buf
    import task_7_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = depth_for(NUM_WORDS_DEFAULT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_adv,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    // A one-word frame still needs a one-bit pointer; storage follows the pointer range.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [0:(2**AW)-1];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (i_wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (i_rd_adv) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/task_7_out.sv
// rtl/task_7_out.sv - collects one result frame and streams it to the sink
module task_7_out
    import task_7_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = NUM_WORDS_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_enb,
    input  logic                  i_tready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tdata_valid,
    output logic                  o_tdata_last,
    output logic                  o_output_last,
    output logic                  o_err
);

    localparam int DEPTH = depth_for(NUM_WORDS);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);

    task_output_enum       state_q;
    logic [CNT_W-1:0]      wr_cnt_q;
    logic [CNT_W-1:0]      rd_cnt_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  out_last_q;
    logic                  err_q;

    logic                  accept_wr;
    logic                  rd_load;
    logic [DATA_WIDTH-1:0] rd_data;

    assign accept_wr = i_enb && (state_q == s_IDLE || state_q == s_COLLECT);
    assign rd_load   = (state_q == s_SEND) && (!valid_q || i_tready) && (rd_cnt_q < CNT_FULL);

    task_7_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (accept_wr),
        .i_wr_data (i_data),
        .i_rd_adv  (rd_load),
        .o_rd_data (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= s_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            tdata_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            out_last_q <= 1'b0;
            if (i_enb && !accept_wr) begin
                err_q <= 1'b1;
            end
            case (state_q)
                s_IDLE: begin
                    if (i_enb) begin
                        wr_cnt_q <= CNT_W'(1);
                        state_q  <= (NUM_WORDS == 1) ? s_SEND : s_COLLECT;
                    end
                end
                s_COLLECT: begin
                    if (i_enb) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        if (wr_cnt_q == CNT_LAST) begin
                            state_q <= s_SEND;
                        end
                    end
                end
                s_SEND: begin
                    // The final handshake retires the frame; no further load is possible then.
                    if (valid_q && i_tready && last_q) begin
                        valid_q    <= 1'b0;
                        last_q     <= 1'b0;
                        out_last_q <= 1'b1;
                        state_q    <= s_DONE;
                    end else if (rd_load) begin
                        tdata_q  <= rd_data;
                        valid_q  <= 1'b1;
                        last_q   <= (rd_cnt_q == CNT_LAST);
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end else if (valid_q && i_tready) begin
                        valid_q <= 1'b0;
                    end
                end
                s_DONE: begin
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                    state_q  <= s_IDLE;
                end
                default: begin
                    state_q <= s_IDLE;
                end
            endcase
        end
    end

    assign o_tdata       = tdata_q;
    assign o_tdata_valid = valid_q;
    assign o_tdata_last  = last_q;
    assign o_output_last = out_last_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_task_7_out.sv
// tb/tb_task_7_out.sv - self-checking bench for the task 7 output stage
module tb_task_7_out;

    localparam int N = 243;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_enb;
    logic       i_tready;
    logic [7:0] o_tdata;
    logic       o_tdata_valid;
    logic       o_tdata_last;
    logic       o_output_last;
    logic       o_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: words collected so far, and completed frames awaiting delivery.
    logic [7:0] coll_q[$];
    logic [7:0] exp_q[$];
    bit         expl_q[$];
    bit         m_err;
    bit         enb_legal;
    int         frame_deliv;

    task_7_out dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_data        (i_data),
        .i_enb         (i_enb),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tdata_valid (o_tdata_valid),
        .o_tdata_last  (o_tdata_last),
        .o_output_last (o_output_last),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit         rst_now;
        bit         stall;
        bit         exp_ol;
        logic [7:0] pdata;
        logic       plast;
        rst_now = i_rst;
        stall   = 1'b0;
        exp_ol  = 1'b0;
        pdata   = o_tdata;
        plast   = o_tdata_last;
        if (!rst_now) begin
            check("spurious_valid", 32'(o_tdata_valid && exp_q.size() == 0), 0);
            if (o_tdata_valid && i_tready && exp_q.size() != 0) begin
                check("tdata", 32'(o_tdata), 32'(exp_q[0]));
                check("tdata_last", 32'(o_tdata_last), 32'(expl_q[0]));
                exp_ol = expl_q[0];
                void'(exp_q.pop_front());
                void'(expl_q.pop_front());
                frame_deliv++;
            end
            stall = o_tdata_valid && !i_tready;
            if (i_enb) begin
                if (enb_legal) begin
                    coll_q.push_back(i_data);
                    if (coll_q.size() == N) begin
                        for (int k = 0; k < N; k++) begin
                            exp_q.push_back(coll_q[k]);
                            expl_q.push_back(k == N - 1);
                        end
                        coll_q.delete();
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge i_clk);
        #1;
        if (rst_now) begin
            coll_q.delete();
            exp_q.delete();
            expl_q.delete();
            m_err       = 1'b0;
            frame_deliv = 0;
            check("rst_tdata", 32'(o_tdata), 0);
            check("rst_valid", 32'(o_tdata_valid), 0);
            check("rst_last", 32'(o_tdata_last), 0);
            check("rst_output_last", 32'(o_output_last), 0);
            check("rst_err", 32'(o_err), 0);
        end else begin
            check("output_last", 32'(o_output_last), 32'(exp_ol));
            check("err", 32'(o_err), 32'(m_err));
            if (stall) begin
                check("stall_valid", 32'(o_tdata_valid), 1);
                check("stall_data", 32'(o_tdata), 32'(pdata));
                check("stall_last", 32'(o_tdata_last), 32'(plast));
            end
        end
    endtask

    // pat: 0 n, 1 n^0x55, 2 0xFF-n, 3 random; gap: 0 none, 1 every 3rd cycle, 2 random
    task automatic send_frame(input int pat, input int gap);
        for (int n = 0; n < N; n++) begin
            i_enb = 1'b0;
            if (gap == 1) begin
                repeat (2) begin
                    tick();
                    check("gap_no_valid", 32'(o_tdata_valid), 0);
                end
            end else if (gap == 2) begin
                repeat ($urandom_range(0, 2)) tick();
            end
            case (pat)
                0:       i_data = 8'(n);
                1:       i_data = 8'(n ^ 'h55);
                2:       i_data = 8'(255 - n);
                default: i_data = 8'($urandom);
            endcase
            i_tready  = 1'($urandom_range(0, 1));
            i_enb     = 1'b1;
            enb_legal = 1'b1;
            tick();
        end
        i_enb = 1'b0;
    endtask

    // mode: 0 ready held high, 1 random ready, 2 alternating with a 5-cycle stall at word 100
    task automatic drain(input int mode);
        bit saw;
        bit stalled;
        saw         = 1'b0;
        stalled     = 1'b0;
        frame_deliv = 0;
        for (int c = 0; c < 4000 && !saw; c++) begin
            if (mode == 0) begin
                i_tready = 1'b1;
            end else if (mode == 1) begin
                i_tready = 1'($urandom_range(0, 1));
            end else begin
                if (frame_deliv == 100 && !stalled) begin
                    stalled  = 1'b1;
                    i_tready = 1'b0;
                    repeat (5) tick();
                end
                i_tready = ((c % 2) == 0);
            end
            tick();
            if (o_output_last) saw = 1'b1;
        end
        check("frame_done", 32'(saw), 1);
        check("frame_drained", 32'(exp_q.size()), 0);
        if (mode == 2) check("bp_stall_hit", 32'(stalled), 1);
        i_tready = 1'b0;
        tick();
    endtask

    initial begin
        i_rst     = 1'b1;
        i_enb     = 1'b0;
        i_data    = '0;
        i_tready  = 1'b0;
        enb_legal = 1'b1;
        m_err     = 1'b0;
        frame_deliv = 0;
        tick();
        tick();
        i_rst = 1'b0;

        // Nominal frame with exact latency and contiguity
        send_frame(0, 0);
        check("lat_send_no_valid", 32'(o_tdata_valid), 0);
        i_tready = 1'b1;
        tick();
        check("lat_first_valid", 32'(o_tdata_valid), 1);
        check("lat_first_data", 32'(o_tdata), 0);
        for (int i = 0; i < N; i++) begin
            check("contig_valid", 32'(o_tdata_valid), 1);
            tick();
        end
        check("out_last_pulse", 32'(o_output_last), 1);
        check("post_frame_valid", 32'(o_tdata_valid), 0);
        i_tready = 1'b0;
        tick();

        // Back-to-back frame with an illegal write during the send
        send_frame(1, 0);
        for (int c = 0; c < 8 && !o_tdata_valid; c++) begin
            i_tready = 1'($urandom_range(0, 1));
            tick();
        end
        check("illegal_wait_valid", 32'(o_tdata_valid), 1);
        i_enb     = 1'b1;
        i_data    = 8'hAA;
        enb_legal = 1'b0;
        tick();
        i_enb     = 1'b0;
        enb_legal = 1'b1;
        check("illegal_err_set", 32'(o_err), 1);
        drain(1);

        // Backpressure with random data
        send_frame(3, 0);
        drain(2);

        // Gapped input
        send_frame(3, 1);
        drain(0);

        // Mid-frame reset after 100 delivered words
        send_frame(0, 0);
        frame_deliv = 0;
        for (int c = 0; c < 400 && frame_deliv < 100; c++) begin
            i_tready = 1'b1;
            tick();
        end
        check("midrst_reached_100", 32'(frame_deliv), 100);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        send_frame(2, 0);
        drain(0);

        // Random gaps and random backpressure
        send_frame(3, 2);
        drain(1);

        check("final_err_clear", 32'(o_err), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/task_7_out.md
# task_7_out

Output stage of the task 7 datapath, directly downstream of the task 7 input stage and its processing core. It collects one frame of `NUM_WORDS` result words presented as `i_data`/`i_enb` and buffers them. It then streams the frame to the external sink over a valid/ready/last handshake. When the last word is accepted it pulses `o_output_last`, which the input stage uses to request the next frame.

## Interface
- `DATA_WIDTH`, 8: width of result words and of `o_tdata`.
- `NUM_WORDS`, 243: words per frame; legal range 1..4096.

- `i_clk`  input  1: single clock; all logic on its rising edge.
- `i_rst`  input  1: reset, synchronous, active-high.
- `i_data`  input  DATA_WIDTH: result word from the processing core.
- `i_enb`  input  1: `i_data` is valid this cycle; one word per asserted cycle.
- `i_tready`  input  1: sink ready.
- `o_tdata`  output  DATA_WIDTH: stream data, registered.
- `o_tdata_valid`  output  1: stream valid, registered.
- `o_tdata_last`  output  1: high with the final word of a frame.
- `o_output_last`  output  1: one-cycle pulse when the frame is fully delivered.
- `o_err`  output  1: sticky flag, set when a word is dropped.

## Operation
- Buffer depth is `DEPTH = 2**$clog2(NUM_WORDS)`, which is 256 at the default.
- The buffer read is combinational from the read pointer (first-word fall-through).
- `wr_cnt` and `rd_cnt` are `$clog2(NUM_WORDS+1)` bits wide. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- State machine, enum `task_output_enum`:
  - `s_IDLE`: on `i_enb`, write the word and set `wr_cnt`=1. Go to `s_COLLECT`, or to `s_SEND` if `NUM_WORDS`==1.
  - `s_COLLECT`: each `i_enb` writes a word and increments `wr_cnt`. The write that makes `wr_cnt`==`NUM_WORDS` moves the state to `s_SEND`.
  - `s_SEND`: loads the output register whenever (`!o_tdata_valid || i_tready`) and `rd_cnt` < `NUM_WORDS`. Each load increments `rd_cnt` and the read pointer.
    - `o_tdata_last` is set on the load where `rd_cnt`==`NUM_WORDS`-1.
    - When the handshake (`valid && ready`) occurs with `o_tdata_last` high, go to `s_DONE` and clear `o_tdata_valid`/`o_tdata_last`.
  - `s_DONE`: `o_output_last`=1 for this single cycle; clear the counters and go to `s_IDLE`.
- Any `i_enb` seen in `s_SEND` or `s_DONE` is dropped and sets `o_err`. `o_err` clears only on reset.
- While `o_tdata_valid && !i_tready`, `o_tdata` and `o_tdata_last` hold stable.

## Timing
- Reset values: `o_tdata`=0, `o_tdata_valid`=0, `o_tdata_last`=0, `o_output_last`=0, `o_err`=0, state `s_IDLE`, pointers and counters 0. Reset has priority over every other event, including reset in the middle of a frame; the buffer contents are discarded.
- The cycle after the `NUM_WORDS`-th `i_enb`, the state is `s_SEND`.
- The cycle after that, `o_tdata_valid`=1 carrying word 0.
- With `i_tready` held high, the frame streams at one word per cycle with no gaps: `NUM_WORDS` consecutive valid cycles.
- `o_output_last` is asserted in the cycle after the final handshake. The block is in `s_IDLE` and accepts `i_enb` the cycle after that.
- Backpressure may stall for any length of time with no loss or duplication.
- `i_tready` is ignored while `o_tdata_valid`=0.

## Structure
- Shared package `task_7_pkg` holds:
  - the enum `task_output_enum {s_IDLE, s_COLLECT, s_SEND, s_DONE}`;
  - the default `NUM_WORDS` localparam;
  - the depth function (power of two ≥ `NUM_WORDS`).
- One sub-module, `task_7_out_buf`: synchronous single-clock buffer with `DEPTH`×`DATA_WIDTH` storage.
  - Ports: write enable/data, read advance, combinational read data.
  - Its pointers are cleared by `i_rst`.
- The FSM, counters and output register live in `task_7_out`.

## Test plan
- **Nominal frame:** 243 consecutive `i_enb` with data 0..242, `i_tready`=1.
  - `o_tdata` shows 0..242 on 243 contiguous valid cycles, starting 2 cycles after the last `i_enb`.
  - `o_tdata_last` is high only with 242.
  - `o_output_last` is a single pulse on the next cycle.
- **Backpressure:** `i_tready` alternates 1/0, plus one 5-cycle low at word 100.
  - All 243 words arrive in order, each exactly once.
  - `o_tdata` is stable during every stall.
- **Gapped input:** `i_enb` on every 3rd cycle.
  - `o_tdata_valid` stays 0 until after the 243rd word.
  - The frame is then sent intact.
- **Illegal write:** one `i_enb` with data 0xAA during `s_SEND`.
  - `o_err` goes high and stays high.
  - The output frame is unchanged and 0xAA never appears.
- **Mid-frame reset:** `i_rst` pulsed after 100 output words.
  - The next cycle shows all outputs 0.
  - A following 243-word frame (data 0xFF−n) streams correctly starting from word 0.
- **Back-to-back frames:** frames 1 and 2 (data n and n^0x55); frame 2 starts right after `o_output_last`.
  - Both frames are correct.
  - The pointers wrap past 255 with no corruption.
